weight_loader: RTL and testbench

- Upstream feeder for the 3x3x3 weight store.
- Accepts a byte stream of kernel weights over a valid/ready handshake and packs CHANNELS consecutive bytes into one lane-parallel write.
- Generates row/col/channel write addresses and the write-enable so one kernel position (all channels) is written per write cycle.
- Pulses done after all (DATA_SIZE+1)^2 positions are written.

---
 rtl/weight_pkg.sv | 20 ++
 rtl/kernel_pos_counter.sv | 37 +++
 rtl/weight_loader.sv | 135 +++++++++++++
 tb/tb_weight_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared types and sizing for the 3x3x3 weight store and its loader/readers.
package weight_pkg;
   localparam int unsigned DATA_WIDTH_DEF   = 8;
   localparam int unsigned DATA_SIZE_DEF    = 2;
   localparam int unsigned CHANNELS_DEF     = 3;
   localparam int unsigned KERNEL_DIM       = DATA_SIZE_DEF + 1;
   localparam int unsigned KERNEL_POSITIONS = KERNEL_DIM * KERNEL_DIM;
   localparam int unsigned ADDR_W           = KERNEL_DIM;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      WRITE,
      DONE
   } loader_state_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/kernel_pos_counter.sv
// Row/col position counter over a (DATA_SIZE+1)^2 kernel, col fastest.
module kernel_pos_counter
   import weight_pkg::*;
#(
   parameter int unsigned DATA_SIZE = DATA_SIZE_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_clr,
   input  logic               i_inc,
   output logic [DATA_SIZE:0] o_row,
   output logic [DATA_SIZE:0] o_col,
   output logic               o_last
);
   localparam logic [DATA_SIZE:0] MAX_IDX = (DATA_SIZE + 1)'(DATA_SIZE);

   logic [DATA_SIZE:0] r_row;
   logic [DATA_SIZE:0] r_col;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_row <= '0;
         r_col <= '0;
      end else if (i_inc) begin
         if (r_col == MAX_IDX) begin
            r_col <= '0;
            r_row <= (r_row == MAX_IDX) ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_row  = r_row;
   assign o_col  = r_col;
   assign o_last = (r_row == MAX_IDX) && (r_col == MAX_IDX);
endmodule

// File: rtl/weight_loader.sv
// Packs CHANNELS streamed bytes per kernel position into one lane-parallel
// weight-store write, walking all positions row-major and pulsing done.
module weight_loader
   import weight_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned DATA_SIZE  = DATA_SIZE_DEF,
   parameter int unsigned CHANNELS   = CHANNELS_DEF
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_start,
   input  logic                                 i_s_valid,
   output logic                                 o_s_ready,
   input  logic [DATA_WIDTH-1:0]                i_s_data,
   output logic                                 o_we,
   output logic [CHANNELS-1:0][DATA_SIZE:0]     o_row_wr,
   output logic [CHANNELS-1:0][DATA_SIZE:0]     o_col_wr,
   output logic [CHANNELS-1:0][DATA_SIZE:0]     o_channel_wr,
   output logic [CHANNELS-1:0][DATA_WIDTH-1:0]  o_wr_data,
   output logic                                 o_busy,
   output logic                                 o_done
);
   localparam int unsigned AW     = DATA_SIZE + 1;
   localparam int unsigned LANE_W = clog2_min1(CHANNELS);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CHANNELS - 1);

   loader_state_t                       r_state;
   logic [LANE_W-1:0]                   r_lane_cnt;
   logic [DATA_WIDTH-1:0]               r_lane [CHANNELS];
   logic                                r_s_ready;
   logic                                r_we;
   logic                                r_busy;
   logic                                r_done;
   logic [CHANNELS-1:0][AW-1:0]         r_row_wr;
   logic [CHANNELS-1:0][AW-1:0]         r_col_wr;
   logic [CHANNELS-1:0][AW-1:0]         r_channel_wr;
   logic [CHANNELS-1:0][DATA_WIDTH-1:0] r_wr_data;

   logic          w_accept;
   logic          w_clr;
   logic          w_inc;
   logic          w_last;
   logic [AW-1:0] w_row;
   logic [AW-1:0] w_col;

   assign w_accept = i_s_valid && r_s_ready;
   assign w_clr    = (r_state == IDLE) && i_start;
   assign w_inc    = (r_state == WRITE);

   kernel_pos_counter #(
      .DATA_SIZE (DATA_SIZE)
   ) u_pos (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (w_clr),
      .i_inc  (w_inc),
      .o_row  (w_row),
      .o_col  (w_col),
      .o_last (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= IDLE;
         r_lane_cnt   <= '0;
         r_s_ready    <= 1'b0;
         r_we         <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_row_wr     <= '0;
         r_col_wr     <= '0;
         r_channel_wr <= '0;
         r_wr_data    <= '0;
         for (int unsigned i = 0; i < CHANNELS; i++) r_lane[i] <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state    <= COLLECT;
                  r_lane_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_s_ready  <= 1'b1;
               end
            end
            COLLECT: begin
               if (w_accept) begin
                  r_lane[r_lane_cnt] <= i_s_data;
                  if (r_lane_cnt == LAST_LANE) begin
                     // The final lane byte bypasses its register so the write
                     // presents in the very next cycle.
                     r_lane_cnt <= '0;
                     r_state    <= WRITE;
                     r_s_ready  <= 1'b0;
                     r_we       <= 1'b1;
                     for (int unsigned i = 0; i < CHANNELS; i++) begin
                        r_wr_data[i]    <= (LANE_W'(i) == r_lane_cnt) ? i_s_data : r_lane[i];
                        r_row_wr[i]     <= w_row;
                        r_col_wr[i]     <= w_col;
                        r_channel_wr[i] <= AW'(i);
                     end
                  end else begin
                     r_lane_cnt <= r_lane_cnt + 1'b1;
                  end
               end
            end
            WRITE: begin
               r_we <= 1'b0;
               if (w_last) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_state   <= COLLECT;
                  r_s_ready <= 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_s_ready    = r_s_ready;
   assign o_we         = r_we;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_row_wr     = r_row_wr;
   assign o_col_wr     = r_col_wr;
   assign o_channel_wr = r_channel_wr;
   assign o_wr_data    = r_wr_data;
endmodule

// File: tb/tb_weight_loader.sv
// Directed/randomized bench for weight_loader against an arithmetic write-order model.
module tb_weight_loader;
   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 s_valid = 1'b0;
   logic                 s_ready;
   logic [7:0]           s_data = '0;
   logic                 we;
   logic [2:0][2:0]      row_wr, col_wr, channel_wr;
   logic [2:0][7:0]      wr_data;
   logic                 busy, done;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [2:0][2:0] row;
      logic [2:0][2:0] col;
      logic [2:0][2:0] ch;
      logic [2:0][7:0] data;
      int              cyc;
   } wr_t;

   wr_t wr_q[$];
   int  acc_q[$];
   int  done_q[$];
   int  cyc = 0;
   int  rdy_hi = 0;
   int  rdy_bad = 0;

   weight_loader #(
      .DATA_WIDTH (8),
      .DATA_SIZE  (2),
      .CHANNELS   (3)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_s_valid    (s_valid),
      .o_s_ready    (s_ready),
      .i_s_data     (s_data),
      .o_we         (we),
      .o_row_wr     (row_wr),
      .o_col_wr     (col_wr),
      .o_channel_wr (channel_wr),
      .o_wr_data    (wr_data),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   // accepts are logged with the cycle in which the byte was presented
   always @(posedge clk) begin
      if (s_valid && s_ready) acc_q.push_back(cyc);
      cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      wr_t e;
      if (we) begin
         e.row = row_wr; e.col = col_wr; e.ch = channel_wr; e.data = wr_data; e.cyc = cyc;
         wr_q.push_back(e);
      end
      if (done) done_q.push_back(cyc);
      if (s_ready) rdy_hi++;
      if ((busy && (s_ready == we)) || (done && s_ready)) rdy_bad++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      wr_q.delete(); acc_q.delete(); done_q.delete();
      rdy_hi = 0; rdy_bad = 0;
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic stream(input int base, input int n, input bit bubbles, input bit mid_start);
      int k = 0;
      int guard = 0;
      bit did = 1'b0;
      bit v, rdy;
      while (k < n && guard < 3000) begin
         rdy = s_ready;
         v = bubbles ? ($urandom_range(0, 2) == 0) : 1'b1;
         s_valid = v;
         s_data = 8'(base + k);
         if (mid_start && !did && k == 12) begin
            start = 1'b1; did = 1'b1;
         end else start = 1'b0;
         @(posedge clk);
         if (v && rdy) k++;
         guard++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      start = 1'b0;
      chk("stream_bytes", 64'(k), 64'(n));
   endtask

   task automatic wait_done();
      for (int w = 0; w < 60 && done_q.size() == 0; w++) @(negedge clk);
      chk("done_seen", 64'(done_q.size() > 0), 64'(1));
      @(negedge clk);
      chk("busy_after", 64'(busy), 64'(0));
      chk("done_after", 64'(done), 64'(0));
   endtask

   // Byte k = base+k lands at position k/3, lane k%3; positions are row-major.
   task automatic check_writes(input int base, input bit continuous);
      logic [2:0][7:0] ed;
      logic [2:0][2:0] er, ec, ech;
      chk("we_count", 64'(wr_q.size()), 64'(9));
      chk("accept_count", 64'(acc_q.size()), 64'(27));
      chk("done_count", 64'(done_q.size()), 64'(1));
      chk("ready_shape", 64'(rdy_bad), 64'(0));
      for (int p = 0; p < 9 && p < wr_q.size(); p++) begin
         for (int c = 0; c < 3; c++) begin
            ed[c] = 8'(base + 3 * p + c);
            er[c] = 3'(p / 3);
            ec[c] = 3'(p % 3);
            ech[c] = 3'(c);
         end
         chk($sformatf("wr_data[%0d]", p), 64'(wr_q[p].data), 64'(ed));
         chk($sformatf("row_wr[%0d]", p), 64'(wr_q[p].row), 64'(er));
         chk($sformatf("col_wr[%0d]", p), 64'(wr_q[p].col), 64'(ec));
         chk($sformatf("channel_wr[%0d]", p), 64'(wr_q[p].ch), 64'(ech));
         if (acc_q.size() > 3 * p + 2)
            chk($sformatf("we_latency[%0d]", p), 64'(wr_q[p].cyc), 64'(acc_q[3 * p + 2] + 1));
      end
      if (done_q.size() == 1 && wr_q.size() == 9)
         chk("done_latency", 64'(done_q[0]), 64'(wr_q[8].cyc + 1));
      if (continuous && done_q.size() == 1 && acc_q.size() > 0)
         chk("total_cycles", 64'(done_q[0] - acc_q[0]), 64'(36));
   endtask

   task automatic run_load(input int base, input bit bubbles, input bit mid_start);
      clear_mon();
      do_start();
      stream(base, 27, bubbles, mid_start);
      wait_done();
      check_writes(base, !bubbles);
   endtask

   initial begin
      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(s_ready), 64'(0));
      chk("rst_we", 64'(we), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_lanes", {row_wr, col_wr, channel_wr, wr_data}, 64'(0));
      rst = 1'b0;

      // basic load, continuous valid
      run_load(8'h00, 1'b0, 1'b0);

      // bubbles on s_valid
      run_load(8'h00, 1'b1, 1'b0);

      // start pulsed mid-load is ignored
      run_load(8'h80, 1'b0, 1'b1);

      // reset mid-operation after 14 bytes
      clear_mon();
      do_start();
      stream(8'h10, 14, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_we", 64'(we), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_ready", 64'(s_ready), 64'(0));
      chk("midrst_done", 64'(done), 64'(0));
      rst = 1'b0;
      run_load(8'h40, 1'b0, 1'b0);

      // idle stream: valid without start
      @(negedge clk);
      clear_mon();
      s_valid = 1'b1;
      s_data = 8'hEE;
      repeat (20) @(negedge clk);
      s_valid = 1'b0;
      chk("idle_ready_hi", 64'(rdy_hi), 64'(0));
      chk("idle_we", 64'(wr_q.size()), 64'(0));
      chk("idle_accepts", 64'(acc_q.size()), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
